// File: rtl/rr_arb_dec4_if.sv
// Arbiter client bundle: request/done from the clients, one-hot grant back.
// master = client side, slave = arbiter side.
interface rr_arb_dec4_if;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_vld;
    logic       timeout;

    modport master (
        output req, done,
        input  gnt, gnt_id, gnt_vld, timeout
    );

    modport slave (
        input  req, done,
        output gnt, gnt_id, gnt_vld, timeout
    );
endinterface

// File: rtl/rr_arb_dec4.sv
// Four-client round-robin arbiter, one-hot grant decoded from a registered winner index.
// Grant 1 cycle after request; owner holds until done/req drop, then a 1-cycle GAP.
// Optional forced release after MAX_HOLD busy cycles when ARB_TIMEOUT_EN is defined.
module rr_arb_dec4 #(
    parameter int MAX_HOLD = 16
) (
    input  logic         clk,
    input  logic         rst,
    rr_arb_dec4_if.slave bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    logic [1:0] state;
    logic [1:0] ptr;
    logic [1:0] gnt_id;
    logic       gnt_vld;
    logic [1:0] winner;
    logic [1:0] idx;
    logic       normal_rel;
    logic       force_rel;

    // Scan from the highest offset down so the nearest requester to ptr wins last.
    always_comb begin
        winner = ptr;
        idx    = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (bus.req[idx]) begin
                winner = idx;
            end
        end
    end

    assign normal_rel = bus.done || !bus.req[gnt_id];

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;
    logic       timeout_q;

    assign force_rel = (hold_cnt == 8'(MAX_HOLD - 1));

    // Counter is held at zero outside BUSY, so it is clear on every BUSY entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt  <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            hold_cnt  <= (state == BUSY) ? hold_cnt + 8'd1 : 8'd0;
            timeout_q <= (state == BUSY) && force_rel && !normal_rel;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign force_rel   = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= 2'd0;
            gnt_id  <= 2'd0;
            gnt_vld <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        gnt_id  <= winner;
                        gnt_vld <= 1'b1;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (normal_rel || force_rel) begin
                        gnt_vld <= 1'b0;
                        ptr     <= gnt_id + 2'd1;
                        state   <= GAP;
                    end
                end
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt     = gnt_vld ? (4'b0001 << gnt_id) : 4'b0000;
    assign bus.gnt_id  = gnt_id;
    assign bus.gnt_vld = gnt_vld;

endmodule

// File: doc/rr_arb_dec4.md
# rr_arb_dec4

Four-requester round-robin arbiter that shares a single resource among four clients and drives a one-hot grant through a 2-to-4 decode of its registered winner index. Each grant is held until the owner signals completion or withdraws its request. A one-cycle dead gap then separates consecutive owners. It sits in front of the shared datapath resource and produces its one-hot select lines.

## Interface
- MAX_HOLD, 16: maximum BUSY cycles before a forced release. Range 2..255. Used only when ARB_TIMEOUT_EN is defined.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req  in  4  request per client; bit i = client i
- done  in  1  current owner finished; sampled only in BUSY
- gnt  out  4  one-hot grant, decode of gnt_id; all zero when gnt_vld=0
- gnt_id  out  2  encoded index of current/last winner
- gnt_vld  out  1  a grant is active
- timeout  out  1  one-cycle pulse on forced release

## Operation
- Reset values: FSM=IDLE, ptr=0, gnt=4'b0000, gnt_id=2'b00, gnt_vld=0, timeout=0, hold counter=0. Reset acts immediately, including mid-grant: gnt drops without waiting for clk.
- FSM states: IDLE, BUSY, GAP.
- **IDLE**
  - If req!=0 at the clock edge, the winner is the first set bit scanning ptr, ptr+1, … modulo 4 (wraps 3→0).
  - Register gnt_id=winner, set gnt_vld=1 and move to BUSY.
  - If req==0, stay in IDLE.
- **BUSY**
  - Release when done=1 or req[gnt_id]=0 at the edge. done and a request drop in the same cycle count as one release.
  - On release: gnt_vld→0, ptr→gnt_id+1 (2-bit wrap, 3→0), move to GAP.
  - Requests from other clients never preempt the owner.
- **GAP**
  - One cycle with gnt=0.
  - Always moves to IDLE; no arbitration happens in this state.
- done outside BUSY is ignored.
- gnt is the combinational decode of registered gnt_id gated by registered gnt_vld, so it is glitch-free relative to the state registers.
- gnt_id holds its last value while gnt_vld=0.
- Fairness: with all four requests held continuously, grants rotate 0,1,2,3,0,…

## Timing
- Request to grant: req sampled at edge n in IDLE → gnt valid after edge n (1-cycle latency).
- Release: done sampled at edge k → gnt=0 after edge k (GAP). IDLE follows after edge k+1, and the next grant appears after edge k+2.
- Minimum owner tenure is 1 cycle: done can be asserted in the first BUSY cycle.
- Back-to-back grants to the same client are allowed if it is the only requester after ptr advances.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A hold counter clears on entry to BUSY and increments each BUSY cycle.
  - When the count reaches MAX_HOLD without a release, a forced release occurs exactly as a normal release: GAP, ptr advance.
  - timeout pulses high for the GAP cycle of a forced release only.
  - A normal release and the MAX_HOLD limit on the same edge count as a normal release, with timeout=0.
- ARB_TIMEOUT_EN undefined: no counter is built, timeout is tied to 0, MAX_HOLD is ignored, and ownership is unbounded.

## Test plan
- Reset during grant: rst=1 while gnt=4'b0100 → gnt=0 and gnt_vld=0 without a clock edge. After release, req=4'b0001 → gnt=4'b0001 one cycle later (ptr back at 0).
- Single requester: req=4'b0100, done pulsed on the 3rd BUSY cycle → gnt=4'b0100 for 3 cycles, 1 GAP cycle, then 4'b0100 again after the IDLE cycle. gnt_id=2.
- Full rotation: req=4'b1111 held, done pulsed each BUSY cycle → grant sequence 0001, 0010, 0100, 1000, 0001, with gnt=0 for 2 cycles between grants.
- Wrap and skip: after a grant to client 3 is released, req=4'b0101 → client 0 is granted (ptr wraps to 0). After that release, client 2 is granted, not client 0 again.
- Request drop and spurious done: owner 1 drops req with done=0 → release with timeout=0. done=1 pulsed in IDLE → no state change.
- ARB_TIMEOUT_EN defined, MAX_HOLD=4: req=4'b0010 held, done=0 → gnt=4'b0010 for 4 cycles, timeout=1 for one cycle in GAP, then client 1 is re-granted.
